corescore_stream_uart: RTL

- Parametrised successor to the fixed emitter stage: accepts the corescorecore AXI-stream byte output and serialises it onto a UART line.
- Adds a buffering FIFO, a baud divisor derived from clock frequency and baud parameters, and selectable stop bits.
- Optional line-feed insertion after each tlast-marked byte.
- Sits between corescorecore and the board's o_uart_tx pin in every corescore board top.

---
 rtl/corescore_pkg.sv | 11 +
 rtl/corescore_sync_fifo.sv | 49 ++++
 rtl/corescore_stream_uart.sv | 111 +++++++++++
 3 files changed

// File: rtl/corescore_pkg.sv
// corescore_pkg: shared constants, TX state encoding and baud divisor helper
//   ASCII_LF   : byte emitted after tlast-marked bytes
//   tx_state_t : UART transmitter states
//   baud_div   : rounded clock cycles per bit
package corescore_pkg;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/corescore_sync_fifo.sv
// corescore_sync_fifo: synchronous FIFO with registered full/empty flags and level
//   clk, rst       : clock, async active-high reset
//   wr_data, push  : write port (ignored while full, even with a same-cycle pop)
//   pop, rd_data   : read port, rd_data shows the head entry (ignored while empty)
//   full, empty    : registered status flags
//   level          : occupancy 0..DEPTH
module corescore_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  logic [AW:0] level_n;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign level_n = level + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level_n;
      full <= level_n == (AW+1)'(DEPTH);
      empty <= level_n == '0;
    end
endmodule

// File: rtl/corescore_stream_uart.sv
// corescore_stream_uart: AXI-stream byte sink buffered into a UART transmitter
//   i_clk, i_rst                 : clock, async active-high reset
//   i_tdata, i_tlast, i_tvalid   : stream input, o_tready back-pressure
//   o_uart_tx                    : registered serial line, idle high
//   o_busy                       : frame in flight, bytes queued or LF pending
//   o_level                      : FIFO occupancy
module corescore_stream_uart
  import corescore_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 16000000,
  parameter int BAUD = 57600,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS = 1,
  parameter int NEWLINE_ON_TLAST = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [7:0]                   i_tdata,
  input  logic                         i_tlast,
  input  logic                         i_tvalid,
  output logic                         o_tready,
  output logic                         o_uart_tx,
  output logic                         o_busy,
  output logic [$clog2(FIFO_DEPTH):0]  o_level
);
  localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD);
  localparam int STOP_CYC = STOP_BITS * DIV;
  localparam int CW = $clog2(STOP_CYC);
  if (DIV < 2) begin : g_bad_div
    $error("baud divisor must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  tx_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic [8:0] head;
  logic ready_q, full, empty, pop, lf_pend, last_q, bit_end, stop_end;
  // ready_q holds o_tready low through the first edge after reset release
  assign o_tready = ready_q & ~full;
  assign o_busy = (state != IDLE) | ~empty | lf_pend;
  assign pop = (state == IDLE) & ~lf_pend & ~empty;
  assign bit_end = cnt == CW'(DIV - 1);
  assign stop_end = cnt == CW'(STOP_CYC - 1);
  corescore_sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .wr_data({i_tlast, i_tdata}),
    .push(i_tvalid & o_tready),
    .pop(pop),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .level(o_level)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      o_uart_tx <= 1'b1;
      lf_pend <= 1'b0;
      last_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (state)
        IDLE: begin
          o_uart_tx <= 1'b1;
          cnt <= '0;
          idx <= '0;
          // inserted LF takes priority; clearing last_q keeps it from chaining another LF
          if (lf_pend) begin
            shift <= ASCII_LF;
            last_q <= 1'b0;
            lf_pend <= 1'b0;
            state <= START;
          end else if (!empty) begin
            shift <= head[7:0];
            last_q <= head[8];
            state <= START;
          end
        end
        START: begin
          o_uart_tx <= 1'b0;
          cnt <= bit_end ? '0 : cnt + 1'b1;
          if (bit_end) state <= DATA;
        end
        DATA: begin
          o_uart_tx <= shift[0];
          cnt <= bit_end ? '0 : cnt + 1'b1;
          if (bit_end) begin
            shift <= shift >> 1;
            idx <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          o_uart_tx <= 1'b1;
          cnt <= stop_end ? '0 : cnt + 1'b1;
          if (stop_end) begin
            state <= IDLE;
            lf_pend <= (NEWLINE_ON_TLAST != 0) && last_q;
          end
        end
      endcase
    end
endmodule
